// File: rtl/ahfp_pkg.sv
// Shared constants and types for the Q3.29 fixed-point accumulator.
package ahfp_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 29;

  localparam logic [DATA_W-1:0] ONE     = 32'h2000_0000;
  localparam logic [DATA_W-1:0] MAX_POS = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] MAX_NEG = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ahfp_sat_narrow.sv
// Signed saturating narrow: clips a wide two's-complement value into OUT_W bits
// and flags when clipping occurred.
module ahfp_sat_narrow #(
  parameter int IN_W  = 48,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  acc_i,
  output logic [OUT_W-1:0] data_o,
  output logic             sat_o
);

  logic fits;

  // The value fits when every bit from the MSB down to the narrow sign bit matches.
  // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    fits  = (acc_i[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){acc_i[IN_W-1]}});
    sat_o = ~fits;
    if (fits) begin
      data_o = acc_i[OUT_W-1:0];
    end else if (acc_i[IN_W-1]) begin
      data_o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      data_o = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/ahfp_fixed_acc.sv
// Streaming Q3.29 accumulator: sums len terms, saturates to 32 bits and hands the
// result downstream over valid/ready.
module ahfp_fixed_acc
  import ahfp_pkg::*;
#(
  parameter int DATA_W = ahfp_pkg::DATA_W,
  parameter int FRAC_W = ahfp_pkg::FRAC_W,
  parameter int CNT_W  = 16,
  parameter int ACC_W  = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              sat
);

  if (FRAC_W >= DATA_W || ACC_W < DATA_W + CNT_W) begin : g_bad_params
    $error("ahfp_fixed_acc: inconsistent FRAC_W/ACC_W");
  end

  state_e              state_q;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    rem_q;
  logic                in_ready_q, out_valid_q, sat_q, busy_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                accept;
  logic [DATA_W-1:0]   narrow_data;
  logic                narrow_sat;

  always_comb begin
    accept = in_valid & in_ready_q;
    acc_d  = acc_q + {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
  end

  // Saturate the post-accept sum so the result is ready in the same edge that enters DONE.
  ahfp_sat_narrow #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W)
  ) u_sat_narrow (
    .acc_i  (acc_d),
    .data_o (narrow_data),
    .sat_o  (narrow_sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= '0;
            busy_q <= 1'b1;
            if (len != '0) begin
              state_q    <= ACC;
              rem_q      <= len;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= '0;
              sat_q       <= 1'b0;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc_q <= acc_d;
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= narrow_data;
              sat_q       <= narrow_sat;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat       = sat_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ahfp_fixed_acc.sv
// Directed bench for ahfp_fixed_acc: sums, saturation, len==0, back-pressure and reset mid-run.
module tb_ahfp_fixed_acc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        sat;

  int checks = 0;
  int errors = 0;

  ahfp_fixed_acc dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one clock and settle 1ns past the edge before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run of n terms (n <= 4), optionally with an idle cycle between terms,
  // and checks the result presented in DONE. Leaves the block waiting for out_ready.
  task automatic do_run(input string name, input int n,
                        input logic [31:0] t0, input logic [31:0] t1,
                        input logic [31:0] t2, input logic [31:0] t3,
                        input bit gap, input logic [31:0] exp_data, input logic exp_sat);
    logic [31:0] tv [4];
    tv[0] = t0; tv[1] = t1; tv[2] = t2; tv[3] = t3;
    in_valid = 1'b0;
    start = 1'b1;
    len = 16'(n);
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy after start: got %b want 1", name, busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready in ACC: got %b want 1", name, in_ready); end
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        in_valid = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL %s stall: in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid); end
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s early out_valid before term %0d: got %b want 0", name, i, out_valid); end
      in_valid = 1'b1;
      in_data = tv[i];
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid after last term: got %b want 1", name, out_valid); end
    checks++; if (out_data !== exp_data) begin errors++; $display("FAIL %s out_data: got %h want %h", name, out_data, exp_data); end
    checks++; if (sat !== exp_sat) begin errors++; $display("FAIL %s sat: got %b want %b", name, sat, exp_sat); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready in DONE: got %b want 0", name, in_ready); end
  endtask

  task automatic finish_run(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s handshake: out_valid=%b busy=%b want 0/0", name, out_valid, busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if ({busy, out_valid, in_ready, sat} !== 4'b0000) begin errors++; $display("FAIL reset flags: busy/out_valid/in_ready/sat got %b want 0000", {busy, out_valid, in_ready, sat}); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset out_data: got %h want 00000000", out_data); end
  endtask

  task automatic test_sum();
    do_run("sum_pos", 3, 32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0, 1'b0, 32'h5000_0000, 1'b0);
    finish_run("sum_pos");
    do_run("sum_neg", 3, 32'h2000_0000, 32'hE000_0000, 32'hF000_0000, 32'h0, 1'b1, 32'hF000_0000, 1'b0);
    finish_run("sum_neg");
  endtask

  task automatic test_saturation();
    do_run("sat_pos", 4, 32'h6000_0000, 32'h6000_0000, 32'h6000_0000, 32'h6000_0000, 1'b0, 32'h7FFF_FFFF, 1'b1);
    finish_run("sat_pos");
    // Back-to-back: the next start goes in the cycle straight after the handshake.
    do_run("sat_neg", 2, 32'hA000_0000, 32'hA000_0000, 32'h0, 32'h0, 1'b0, 32'h8000_0000, 1'b1);
    finish_run("sat_neg");
    do_run("edge_max", 2, 32'h4000_0000, 32'h3FFF_FFFF, 32'h0, 32'h0, 1'b0, 32'h7FFF_FFFF, 1'b0);
    finish_run("edge_max");
    do_run("edge_over", 2, 32'h4000_0000, 32'h4000_0000, 32'h0, 32'h0, 1'b0, 32'h7FFF_FFFF, 1'b1);
    finish_run("edge_over");
    do_run("edge_min", 2, 32'hC000_0000, 32'hC000_0000, 32'h0, 32'h0, 1'b0, 32'h8000_0000, 1'b0);
    finish_run("edge_min");
  endtask

  task automatic test_len_zero();
    start = 1'b1;
    len = 16'd0;
    in_valid = 1'b1;
    in_data = 32'h2000_0000;
    tick();
    start = 1'b0;
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL len0 out_valid/busy: got %b/%b want 1/1", out_valid, busy); end
    checks++; if (out_data !== 32'h0 || sat !== 1'b0) begin errors++; $display("FAIL len0 result: got %h sat %b want 00000000 sat 0", out_data, sat); end
    tick();
    checks++; if (in_ready !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL len0 hold: in_ready=%b out_data=%h want 0/00000000", in_ready, out_data); end
    in_valid = 1'b0;
    finish_run("len0");
  endtask

  task automatic test_backpressure();
    do_run("bp", 3, 32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0, 1'b0, 32'h5000_0000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      start = 1'b1;
      len = 16'd2;
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h5000_0000) begin errors++; $display("FAIL bp hold cycle %0d: out_valid=%b out_data=%h want 1/50000000", c, out_valid, out_data); end
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || sat !== 1'b0) begin errors++; $display("FAIL bp flags cycle %0d: in_ready=%b busy=%b sat=%b want 0/1/0", c, in_ready, busy, sat); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp handshake with start: busy=%b out_valid=%b want 0/0", busy, out_valid); end
    start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL bp idle after: busy=%b in_ready=%b want 0/0", busy, in_ready); end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    len = 16'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h2000_0000;
    tick();
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({busy, out_valid, in_ready} !== 3'b000) begin errors++; $display("FAIL midreset flags: busy/out_valid/in_ready got %b want 000", {busy, out_valid, in_ready}); end
    // A term offered while idle must not leak into the next sum.
    in_valid = 1'b1;
    in_data = 32'h6000_0000;
    tick();
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle term: in_ready=%b busy=%b want 0/0", in_ready, busy); end
    do_run("after_reset", 1, 32'h2000_0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h2000_0000, 1'b0);
    finish_run("after_reset");
  endtask

  initial begin
    test_reset();
    test_sum();
    test_saturation();
    test_len_zero();
    test_backpressure();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahfp_fixed_acc.md
Name: ahfp_fixed_acc

Overview:
Streaming signed fixed-point accumulator that sits directly upstream of the fixed-to-float converter.
- Sums a programmed number of Q3.29 terms (0x20000000 = 1.0, two's complement, range [-4, 4)).
- Saturates the sum back to 32-bit Q3.29.
- Presents the sum on a valid/ready output whose data feeds the converter's 32-bit fixed input directly.

Parameters:
- DATA_W, 32, width of input terms and output sum (Q3.29).
- FRAC_W, 29, fractional bits. Informational only; the datapath is format-agnostic.
- CNT_W, 16, width of term-count input.
- ACC_W, DATA_W+CNT_W (48), internal accumulator width. Sized so no internal overflow is possible for any len.

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, begin a run. Honoured only in IDLE.
- len, in, CNT_W, number of terms in the run. Sampled with start.
- in_valid, in, 1, input term valid.
- in_data, in, DATA_W, signed Q3.29 term.
- in_ready, out, 1, block accepts a term this cycle.
- out_valid, out, 1, sum available.
- out_data, out, DATA_W, saturated signed Q3.29 sum.
- out_ready, in, 1, consumer takes the sum.
- busy, out, 1, high when not IDLE.
- sat, out, 1, out_data was clipped. Valid while out_valid.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `reset`. All state and outputs are registered.
- Reset values: state=IDLE, acc=0, remaining=0, in_ready=0, out_valid=0, out_data=0, sat=0, busy=0.
- States: IDLE, ACC, DONE.
- IDLE:
  - in_ready=0.
  - start=1 and len!=0 -> ACC: acc<=0, remaining<=len.
  - start=1 and len==0 -> DONE: acc<=0, out_data=0, sat=0.
- ACC:
  - in_ready=1.
  - On in_valid&in_ready: acc <= acc + sign-extend(in_data) to ACC_W; remaining decrements.
  - On the accept where remaining==1 -> DONE.
  - in_valid low: hold; no timeout.
- DONE:
  - out_valid=1, in_ready=0.
  - out_data and sat are registered on entry and stay stable until handshake.
  - out_valid&out_ready -> IDLE; out_valid drops the next cycle.
- Saturation on entry to DONE:
  - acc > 2^31-1 -> out_data=0x7FFFFFFF, sat=1.
  - acc < -2^31 -> out_data=0x80000000, sat=1.
  - Otherwise out_data = acc[31:0], sat=0.
- Latency: out_valid rises in the cycle after the last term is accepted. With len==0, it rises in the cycle after start.
- Throughput: one term per cycle in ACC. Minimum idle gap between runs is 1 cycle (the DONE->IDLE transition).
- start while busy: ignored, including in the cycle of the DONE handshake. len is not resampled.
- Reset mid-run (any state): next cycle is IDLE with all reset values. Partial sum is discarded and no out_valid is produced.
- in_valid outside ACC: term ignored, not counted.

Decomposition:
- Package ahfp_pkg holds:
  - DATA_W, FRAC_W constants.
  - Q3.29 constants ONE=0x20000000, MAX_POS=0x7FFFFFFF, MAX_NEG=0x80000000.
  - State enum {IDLE, ACC, DONE}.
- One sub-module: ahfp_sat_narrow. Combinational ACC_W -> DATA_W signed saturating narrow producing data and sat. It is reusable by later stages.

Test Plan:
1. len=3; terms 0x20000000, 0x20000000, 0x10000000 at one per cycle -> out_data=0x50000000 (2.5), sat=0, out_valid exactly 1 cycle after 3rd accept.
2. len=3; terms 0x20000000, 0xE0000000, 0xF0000000 -> out_data=0xF0000000 (-0.5), sat=0.
3. len=4; terms 0x60000000 ×4 (sum 12.0) -> out_data=0x7FFFFFFF, sat=1. Then len=2, 0xA0000000 ×2 (sum -6.0) -> 0x80000000, sat=1.
4. start with len=0 -> one cycle later out_valid=1, out_data=0x00000000, sat=0. No terms accepted (in_ready stays 0).
5. Run of case 1 with out_ready held low 5 cycles and start pulsed meanwhile -> out_valid/out_data stable at 0x50000000, in_ready=0, start ignored. IDLE reached 1 cycle after out_ready=1.
6. len=4, reset asserted after 2 accepted terms -> next cycle busy=0, out_valid=0, in_ready=0. New run len=1, term 0x20000000 -> out_data=0x20000000; no stale partial sum.
